widths_cat_join: RTL and testbench
==================================

WIDTHS_CAT_JOIN -- requirements
Module: widths_cat_join

Interface
REQ-001 Parameter WIDTH_A, default 5, SHALL set the width of the A-side field, which forms the upper bits of the output word.
REQ-002 Parameter WIDTH_B, default 3, SHALL set the width of the B-side field, which forms the lower bits of the output word.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the pair counter.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 a_valid  input  1  SHALL indicate that the A-side source is offering a_data.
REQ-007 a_data  input  WIDTH_A  SHALL carry the A field.
REQ-008 a_ready  output  1  SHALL indicate that the A field is accepted this cycle.
REQ-009 b_valid  input  1  SHALL indicate that the B-side source is offering b_data.
REQ-010 b_data  input  WIDTH_B  SHALL carry the B field.
REQ-011 b_ready  output  1  SHALL indicate that the B field is accepted this cycle.
REQ-012 out_valid  output  1  SHALL indicate that out_data holds a joined word.
REQ-013 out_data  output  WIDTH_A+WIDTH_B  SHALL carry the joined word {A, B}.
REQ-014 out_ready  input  1  SHALL indicate that the sink is accepting the joined word.
REQ-015 flush  input  1  SHALL be a synchronous discard of held partial fields.
REQ-016 pair_count  output  CNT_W  SHALL report the number of output handshakes completed since reset.
REQ-017 flush_drop  output  1  SHALL pulse for one cycle when a flush discards at least one held field.

Function
REQ-018 The block SHALL hold one A entry and one B entry; a side's handshake SHALL occur when valid and ready are both high.
REQ-019 Join state SHALL be one of EMPTY, HAVE_A, HAVE_B or PAIRED, derived from the A and B holding flags.
REQ-020 A move SHALL be defined as move = PAIRED & (!out_valid | out_ready).
REQ-021 On a move, the output register SHALL load {a_hold, b_hold}, and both holding flags SHALL clear in the same edge.
REQ-022 a_ready SHALL equal (!a_full | move) & !flush; b_ready SHALL equal (!b_full | move) & !flush. These are combinational in out_ready.
REQ-023 If a side's handshake coincides with a move, the new field SHALL be held and that side's flag SHALL remain set.
REQ-024 Latency SHALL be two cycles: both fields accepted in cycle N, PAIRED in N+1, out_valid high in N+2.
REQ-025 Sustained throughput SHALL be one word per cycle while out_ready is held high.
REQ-026 out_valid and out_data SHALL remain stable while out_valid & !out_ready.
REQ-027 pair_count SHALL increment by 1 on each out_valid & out_ready and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 Flush SHALL clear both holding flags and SHALL NOT affect the output register or pair_count.
REQ-029 flush_drop SHALL be registered, high in the cycle after a flush with any flag set.
REQ-030 Flush SHALL suppress any move in the same cycle.
REQ-031 Repeated arrivals on one side while the other is absent SHALL be back-pressured (ready low); no field SHALL be overwritten.

Reset
REQ-032 rst_n low SHALL immediately clear: a_full, b_full, out_valid, flush_drop and pair_count to 0, and out_data to all-zeros; state SHALL be EMPTY.
REQ-033 Reset asserted mid-operation SHALL discard held fields and the pending output word without any output handshake.
REQ-034 The first handshake SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-035 Shared package widths_pkg SHALL hold the join-state enum (EMPTY, HAVE_A, HAVE_B, PAIRED).
REQ-036 Sub-module widths_hold_reg SHALL implement the single-entry hold register (data plus full flag, parameterized width), instantiated once for A and once for B.

Verification
REQ-037 Reset, then a=5'h1A and b=3'h5 both offered in cycle 0 -> out_valid in cycle 2 with out_data=8'hD5, pair_count becomes 1 after the handshake.
REQ-038 a offered in cycle 0, b in cycle 4 -> a_ready is low in cycles 1-4 for a second A, and the output equals {first A, B}.
REQ-039 out_ready held low for 5 cycles with three pairs offered -> out_data is stable, no A or B is lost, and the words emerge in order once out_ready rises.
REQ-040 HAVE_A plus flush -> flush_drop pulses once, state is EMPTY, and out_valid is unchanged.
REQ-041 pair_count preset by 2^CNT_W handshakes (CNT_W=4: 16 handshakes) -> the counter wraps to 0.
REQ-042 rst_n asserted while in PAIRED with out_valid high -> all outputs are 0 immediately and no handshake is counted.

Source files
------------

// File: rtl/widths_pkg.sv
// Shared types for the A/B field join block.
// Join state is the concatenation {a_full, b_full} of the two holding flags.
package widths_pkg;

  typedef enum logic [1:0] {
    StEmpty  = 2'b00,
    StHaveB  = 2'b01,
    StHaveA  = 2'b10,
    StPaired = 2'b11
  } join_state_e;

endpackage

// File: rtl/widths_hold_reg.sv
// Single-entry hold register: a data field plus a full flag.
// A load wins over a clear in the same edge, so a field arriving during a move is kept.
module widths_hold_reg #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic [Width-1:0] data_d, data_q;
  logic             full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/widths_cat_join.sv
// Joins one A field and one B field into a registered {A, B} output word,
// counts output handshakes and supports a synchronous flush of held fields.
module widths_cat_join
  import widths_pkg::*;
#(
  parameter int unsigned WIDTH_A = 5,
  parameter int unsigned WIDTH_B = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  input  logic [WIDTH_A-1:0]         a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [WIDTH_B-1:0]         b_data,
  output logic                       b_ready,
  output logic                       out_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [CNT_W-1:0]           pair_count,
  output logic                       flush_drop
);

  localparam int unsigned WidthOut = WIDTH_A + WIDTH_B;

  logic [WIDTH_A-1:0]  a_hold;
  logic [WIDTH_B-1:0]  b_hold;
  logic                a_full, b_full;
  logic                a_hs, b_hs, move, out_hs;
  join_state_e         state;

  logic                out_valid_d, out_valid_q;
  logic [WidthOut-1:0] out_data_d, out_data_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                flush_drop_d, flush_drop_q;

  assign state   = join_state_e'({a_full, b_full});
  // Flush blocks the move so a discarded pair never reaches the output.
  assign move    = (state == StPaired) & (!out_valid_q | out_ready) & !flush;
  assign a_ready = (!a_full | move) & !flush;
  assign b_ready = (!b_full | move) & !flush;
  assign a_hs    = a_valid & a_ready;
  assign b_hs    = b_valid & b_ready;
  assign out_hs  = out_valid_q & out_ready;

  widths_hold_reg #(
    .Width (WIDTH_A)
  ) u_hold_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (a_hs),
    .clear_i (move | flush),
    .data_i  (a_data),
    .data_o  (a_hold),
    .full_o  (a_full)
  );

  widths_hold_reg #(
    .Width (WIDTH_B)
  ) u_hold_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (b_hs),
    .clear_i (move | flush),
    .data_i  (b_data),
    .data_o  (b_hold),
    .full_o  (b_full)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_hs) out_valid_d = 1'b0;
    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = {a_hold, b_hold};
    end
    cnt_d        = out_hs ? cnt_q + CNT_W'(1) : cnt_q;
    flush_drop_d = flush & (a_full | b_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      cnt_q        <= '0;
      flush_drop_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cnt_q        <= cnt_d;
      flush_drop_q <= flush_drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pair_count = cnt_q;
  assign flush_drop = flush_drop_q;

endmodule

// File: tb/tb_widths_cat_join.sv
// Scoreboard bench for widths_cat_join: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_widths_cat_join;

  localparam int Timeout = 200;

  logic       clk, rst_n;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [4:0] a_data;
  logic [2:0] b_data;
  logic       out_valid, out_ready, flush, flush_drop;
  logic [7:0] out_data;
  logic [3:0] pair_count;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] mcnt     = '0;

  widths_cat_join #(
    .WIDTH_A (5),
    .WIDTH_B (3),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .pair_count (pair_count),
    .flush_drop (flush_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] d);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    while (!done && n < Timeout) begin
      @(negedge clk);
      done = a_ready;
      n++;
      sync();
    end
    a_valid = 1'b0;
    if (!done) check("a_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drive_b(input logic [2:0] d);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    b_valid = 1'b1;
    b_data  = d;
    while (!done && n < Timeout) begin
      @(negedge clk);
      done = b_ready;
      n++;
      sync();
    end
    b_valid = 1'b0;
    if (!done) check("b_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_pair(input logic [4:0] a, input logic [2:0] b);
    fork
      drive_a(a);
      drive_b(b);
    join
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt = '0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_data, $time);
        end else begin
          check("word", 32'(out_data), 32'(exp_q.pop_front()));
        end
        check("pair_count_at_hs", 32'(pair_count), 32'(mcnt));
        mcnt = mcnt + 4'd1;
      end
    end
  end

  initial begin
    logic [7:0] held;
    logic [4:0] av;
    logic [2:0] bv;
    time        t0;

    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    out_ready = 1'b1;
    flush = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_pair_count", 32'(pair_count), 32'd0);
    check("rst_flush_drop", 32'(flush_drop), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    #9 rst_n = 1'b1;

    // Both fields in cycle 0 -> out_valid in cycle 2, {1A,5} = D5.
    sync();
    exp_q.push_back(8'hD5);
    a_valid = 1'b1; a_data = 5'h1A;
    b_valid = 1'b1; b_data = 3'h5;
    @(negedge clk);
    check("lat_ready", 32'({a_ready, b_ready}), 32'd3);
    sync();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'hD5);
    @(negedge clk);
    check("lat_count", 32'(pair_count), 32'd1);

    // A early, B late: second A is back-pressured until the pair moves.
    sync();
    exp_q.push_back(8'h1A);
    exp_q.push_back(8'hFF);
    drive_a(5'h03);
    a_valid = 1'b1; a_data = 5'h1F;
    repeat (4) begin
      @(negedge clk);
      check("a_backpressure", 32'(a_ready), 32'd0);
    end
    sync();
    fork
      drive_a(5'h1F);
      drive_b(3'h2);
    join
    drive_b(3'h7);
    drain();

    // Output stalled while three pairs are offered.
    sync();
    out_ready = 1'b0;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hF6);
    fork
      begin
        send_pair(5'h01, 3'h1);
        send_pair(5'h10, 3'h0);
        send_pair(5'h1E, 3'h6);
      end
      begin
        wait_valid("stall_valid");
        held = out_data;
        check("stall_first", 32'(held), 32'h09);
        repeat (5) begin
          @(negedge clk);
          check("stall_stable", 32'({out_valid, out_data}), 32'({1'b1, held}));
        end
        sync();
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush while HAVE_A with a word pending on the output.
    sync();
    out_ready = 1'b0;
    exp_q.push_back(8'h8B);
    send_pair(5'h11, 3'h3);
    wait_valid("flush_pending");
    sync();
    drive_a(5'h0A);
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 32'({a_ready, b_ready}), 32'd0);
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("flush_drop_pulse", 32'(flush_drop), 32'd1);
    check("flush_out_kept", 32'({out_valid, out_data}), 32'h18B);
    check("flush_empty", 32'({a_ready, b_ready}), 32'd3);
    @(negedge clk);
    check("flush_drop_once", 32'(flush_drop), 32'd0);
    sync();
    out_ready = 1'b1;
    exp_q.push_back(8'hA9);
    send_pair(5'h15, 3'h1);
    drain();

    // 16 back-to-back pairs: one per cycle, counter wraps past 15.
    sync();
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      av = 5'(i);
      bv = 3'(i);
      exp_q.push_back({av, bv});
      send_pair(av, bv);
    end
    check("throughput_cycles", 32'(($time - t0) / 10), 32'd16);
    drain();
    @(negedge clk);
    check("count_wrapped", 32'(pair_count), 32'd8);

    // Reset while PAIRED with out_valid high: nothing emerges or is counted.
    sync();
    out_ready = 1'b0;
    send_pair(5'h07, 3'h1);
    send_pair(5'h02, 3'h6);
    wait_valid("rst_pending");
    sync();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_pair_count", 32'(pair_count), 32'd0);
    check("midrst_flush_drop", 32'(flush_drop), 32'd0);
    check("midrst_ready", 32'({a_ready, b_ready}), 32'd3);
    sync();
    out_ready = 1'b1;
    repeat (2) sync();
    rst_n = 1'b1;
    exp_q.push_back(8'h64);
    fork
      send_pair(5'h0C, 3'h4);
      begin
        @(negedge clk);
        check("first_edge_ready", 32'({a_ready, b_ready}), 32'd3);
      end
    join
    drain();
    repeat (3) @(negedge clk);
    check("final_count", 32'(pair_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
